counter_updown_param: RTL and testbench
=======================================

Name: counter_updown_param

Overview:
- Parametrised up/down counter with synchronous parallel load, enable, programmable modulus and registered ripple-carry pulse.
- Selectable wrap (free-running) or one-shot (stop-at-terminal) mode via a small run/halt state machine.
- Next-generation general counter primitive for the FSM labs: timers, divided-clock enables, and loop counters in datapath controllers.

Parameters:
- WIDTH, 32, counter and load-data width in bits; legal range 2..32.
- MAX, {WIDTH{1'b1}}, terminal value for up-count and reload value for down-count wrap. Must satisfy 1 <= MAX <= 2^WIDTH-1; enforce with an elaboration-time check.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  synchronous parallel load; highest functional priority.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- mode  input  1  0 = wrap, 1 = one-shot.
- pdata  input  WIDTH  load value.
- cnt  output  WIDTH  registered count.
- rc  output  1  registered single-cycle terminal/ripple-carry pulse.
- done  output  1  high while in HALT (one-shot finished).

Behaviour:
- One clock; reset is asynchronous and active-low. On rst_n=0: cnt=0, rc=0, done=0, state=RUN, all immediately, independent of clk.
- States: RUN and HALT. done = (state==HALT), decoded from a registered state bit.
- Terminal condition T = (up && cnt==MAX) || (!up && cnt==0), evaluated on the current registered cnt.
- Per-edge priority: reset > load > HALT hold > en=0 hold > count.
- load=1 (any state):
  - cnt <= (pdata > MAX) ? MAX : pdata (saturating clip).
  - rc <= 0; state <= RUN.
  - en, up and mode are ignored that cycle.
- HALT, load=0: cnt holds and rc <= 0. en and mode are ignored. Exit is only by load or reset.
- RUN, en=0: cnt holds; rc <= 0.
- RUN, en=1, T=0: cnt <= cnt+1 if up, else cnt-1; rc <= 0.
- RUN, en=1, T=1, mode=0 (wrap):
  - cnt <= 0 if up, else MAX.
  - rc <= 1 for exactly the cycle following that edge.
- RUN, en=1, T=1, mode=1 (one-shot):
  - cnt holds (MAX or 0); rc <= 1 for one cycle; state <= HALT.
  - done is high from the same edge.
- Latency:
  - cnt changes one edge after the qualifying inputs.
  - rc is high in the same cycle cnt shows the wrapped value (wrap mode) or the first held cycle (one-shot).
- Back-to-back wraps: with MAX=1 and continuous en, rc may be high on consecutive terminal events; each event is a separate pulse, with no stretching across non-terminal cycles.
- Direction change mid-count takes effect at the next edge. T is re-evaluated with the new up, so a down-count sitting at 0 with up=1 increments normally.
- The counter never leaves [0, MAX], by construction plus the load clip.
- Arithmetic is WIDTH-bit unsigned; no carry-out beyond rc.
- Reset asserted mid-count or mid-HALT returns to the reset values immediately. The first edge after rst_n deasserts is a normal functional edge.

Decomposition:
- Shared package/header counter_defs:
  - State encoding constants ST_RUN=1'b0, ST_HALT=1'b1.
  - Mode constants MODE_WRAP=1'b0, MODE_ONESHOT=1'b1.
- Single module, no sub-module. Terminal detect and next-count mux are inline combinational logic feeding one registered always block.

Test Plan (WIDTH=8, MAX=9 unless noted):
- Reset mid-count: count up to 5, drop rst_n between edges -> cnt=0, rc=0, done=0 immediately; release, en=1, up=1 -> cnt=1 after the first edge.
- Wrap up: load 7, en=1, up=1, mode=0 -> cnt 8,9,0,1 with rc=1 only in the cycle cnt=0. Wrap down from 1 -> cnt 0,9,8 with rc=1 only in the cycle cnt=9.
- One-shot down: load 3, mode=1, up=0, en=1 -> cnt 2,1,0,0,0; rc=1 for one cycle at the first held 0; done=1 and stays 1. A later load of 4 -> cnt=4, done=0.
- Load priority and clip: load=1, en=1, pdata=200 -> cnt=9, rc=0. Same with pdata=4 while in HALT -> cnt=4, state RUN.
- Enable/direction: en=0 for 3 cycles at cnt=6 -> holds 6, rc=0. Toggle up from 1 to 0 at cnt=6 -> next cnt=5.
- Defaults (WIDTH=32, MAX=32'hFFFFFFFF): load 32'hFFFFFFFE, up -> FFFFFFFF, then 0 with rc=1. Down from 0 -> FFFFFFFF with rc=1.

Source files
------------

// File: rtl/counter_defs.sv
`default_nettype none
// ============================================================================
// Module      : counter_defs (package)
// Description : Shared encodings for the up/down counter primitive: the
//               run/halt state and the wrap/one-shot mode select.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_defs;

  // Run/halt state; done is decoded directly from this registered bit.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Terminal-event behaviour select.
  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage : counter_defs
`default_nettype wire

// File: rtl/counter_updown_param.sv
`default_nettype none
// ============================================================================
// Module      : counter_updown_param
// Description : Parametrised up/down counter with synchronous saturating
//               load, count enable, programmable terminal value MAX, a
//               registered single-cycle ripple-carry pulse and a wrap /
//               one-shot mode selected through a run/halt state machine.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   load   in   1      synchronous parallel load (highest functional priority)
//   en     in   1      count enable
//   up     in   1      1 = increment, 0 = decrement
//   mode   in   1      0 = wrap, 1 = one-shot
//   pdata  in   WIDTH  load value (clipped to MAX)
//   cnt    out  WIDTH  registered count, always within [0, MAX]
//   rc     out  1      registered terminal / ripple-carry pulse
//   done   out  1      high while halted after a one-shot terminal event
// ============================================================================
module counter_updown_param
  import counter_defs::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic             mode,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] cnt,
  output logic             rc,
  output logic             done
);

  // MAX is WIDTH bits wide, so the upper bound 2^WIDTH-1 holds by type;
  // only the lower bound and the width range need an explicit check.
  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("counter_updown_param: WIDTH must be in 2..32");
    end
    if (MAX == '0) begin : g_bad_max
      $error("counter_updown_param: MAX must be at least 1");
    end
  endgenerate

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             rc_nxt;
  logic             term;
  logic [WIDTH-1:0] load_val;

  // Terminal depends on the direction presented this cycle, so a
  // down-count parked at 0 simply increments once up is raised.
  assign term     = up ? (cnt == MAX) : (cnt == '0);
  assign load_val = (pdata > MAX) ? MAX : pdata;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rc_nxt    = 1'b0;
    if (load) begin
      cnt_nxt   = load_val;
      state_nxt = ST_RUN;
    end else if (state == ST_HALT) begin
      // Parked until load or reset; en and mode have no effect here.
      cnt_nxt = cnt;
    end else if (!en) begin
      cnt_nxt = cnt;
    end else if (!term) begin
      cnt_nxt = up ? (cnt + 1'b1) : (cnt - 1'b1);
    end else begin
      rc_nxt = 1'b1;
      if (mode == MODE_ONESHOT) begin
        state_nxt = ST_HALT;
      end else begin
        cnt_nxt = up ? '0 : MAX;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= '0;
      rc    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rc    <= rc_nxt;
    end
  end

  assign done = (state == ST_HALT);

endmodule : counter_updown_param
`default_nettype wire

// File: tb/tb_counter_updown_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_updown_param
// Description : Self-checking bench for counter_updown_param. Instance "a"
//               is WIDTH=8/MAX=9, instance "b" uses the default parameters.
//               Each test queues stimulus and expected outputs, then
//               replays them one clock at a time and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_updown_param;

  logic        clk;
  logic        rst_n;

  logic        a_load, a_en, a_up, a_mode;
  logic [7:0]  a_pdata, a_cnt;
  logic        a_rc, a_done;

  logic        b_load, b_en, b_up, b_mode;
  logic [31:0] b_pdata, b_cnt;
  logic        b_rc, b_done;

  int checks;
  int failures;

  typedef struct {
    logic        load;
    logic        en;
    logic        up;
    logic        mode;
    logic [31:0] pdata;
  } stim_t;

  typedef struct {
    logic [31:0] cnt;
    logic        rc;
    logic        done;
  } exp_t;

  stim_t stq[$];
  exp_t  sbq[$];

  counter_updown_param #(.WIDTH(8), .MAX(8'd9)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (a_load),
    .en    (a_en),
    .up    (a_up),
    .mode  (a_mode),
    .pdata (a_pdata),
    .cnt   (a_cnt),
    .rc    (a_rc),
    .done  (a_done)
  );

  counter_updown_param u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (b_load),
    .en    (b_en),
    .up    (b_up),
    .mode  (b_mode),
    .pdata (b_pdata),
    .cnt   (b_cnt),
    .rc    (b_rc),
    .done  (b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue one cycle of stimulus and the outputs expected after that edge.
  task automatic plan(input logic ld, input logic e, input logic u, input logic md,
                      input logic [31:0] pd, input logic [31:0] c,
                      input logic r, input logic d);
    stq.push_back('{ld, e, u, md, pd});
    sbq.push_back('{c, r, d});
  endtask

  // Replays the queued cycles on instance a and compares each result.
  task automatic run_a(input string name);
    stim_t s;
    exp_t  e;
    int    step;
    step = 0;
    while (stq.size() > 0) begin
      s = stq.pop_front();
      a_load = s.load; a_en = s.en; a_up = s.up; a_mode = s.mode;
      a_pdata = s.pdata[7:0];
      tick();
      e = sbq.pop_front();
      checks++;
      if ({a_cnt, a_rc, a_done} !== {e.cnt[7:0], e.rc, e.done}) begin
        failures++;
        $display("FAIL %s step %0d: got cnt=%0d rc=%b done=%b, want cnt=%0d rc=%b done=%b",
                 name, step, a_cnt, a_rc, a_done, e.cnt[7:0], e.rc, e.done);
      end
      step++;
    end
    a_load = 1'b0; a_en = 1'b0;
  endtask

  task automatic test_reset();
    a_load = 0; a_en = 0; a_up = 1; a_mode = 0; a_pdata = '0;
    b_load = 0; b_en = 0; b_up = 1; b_mode = 0; b_pdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_cnt, a_rc, a_done} !== {8'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_a: got cnt=%0d rc=%b done=%b, want 0 0 0", a_cnt, a_rc, a_done);
    end
    checks++;
    if ({b_cnt, b_rc, b_done} !== {32'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_b: got cnt=%0h rc=%b done=%b, want 0 0 0", b_cnt, b_rc, b_done);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) plan(0, 1, 1, 0, 0, i, 0, 0);
    run_a("count_to_5");
    // Drop reset between edges: outputs must clear without a clock edge.
    a_en = 1'b1; a_up = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_cnt, a_rc, a_done} !== {8'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid: got cnt=%0d rc=%b done=%b, want 0 0 0", a_cnt, a_rc, a_done);
    end
    rst_n = 1'b1;
    plan(0, 1, 1, 0, 0, 1, 0, 0);
    run_a("after_reset");
  endtask

  task automatic test_wrap();
    plan(1, 1, 1, 0, 7, 7, 0, 0);
    plan(0, 1, 1, 0, 0, 8, 0, 0);
    plan(0, 1, 1, 0, 0, 9, 0, 0);
    plan(0, 1, 1, 0, 0, 0, 1, 0);
    plan(0, 1, 1, 0, 0, 1, 0, 0);
    run_a("wrap_up");
    plan(1, 1, 0, 0, 1, 1, 0, 0);
    plan(0, 1, 0, 0, 0, 0, 0, 0);
    plan(0, 1, 0, 0, 0, 9, 1, 0);
    plan(0, 1, 0, 0, 0, 8, 0, 0);
    run_a("wrap_down");
  endtask

  task automatic test_oneshot();
    plan(1, 1, 0, 1, 3, 3, 0, 0);
    plan(0, 1, 0, 1, 0, 2, 0, 0);
    plan(0, 1, 0, 1, 0, 1, 0, 0);
    plan(0, 1, 0, 1, 0, 0, 0, 0);
    plan(0, 1, 0, 1, 0, 0, 1, 1);
    plan(0, 1, 0, 1, 0, 0, 0, 1);
    plan(0, 1, 0, 1, 0, 0, 0, 1);
    plan(0, 1, 1, 0, 0, 0, 0, 1);   // halted: en, up, mode have no effect
    plan(1, 0, 0, 0, 4, 4, 0, 0);
    plan(0, 1, 1, 0, 0, 5, 0, 0);
    run_a("oneshot");
  endtask

  task automatic test_load_priority();
    plan(1, 1, 1, 0, 200, 9, 0, 0);
    plan(1, 1, 1, 0, 10, 9, 0, 0);
    plan(1, 1, 1, 0, 9, 9, 0, 0);
    plan(1, 1, 1, 0, 4, 4, 0, 0);   // at terminal with en: load wins, no rc
    plan(1, 0, 0, 1, 0, 0, 0, 0);
    plan(0, 1, 0, 1, 0, 0, 1, 1);
    plan(1, 1, 0, 1, 4, 4, 0, 0);   // load out of HALT
    plan(0, 1, 0, 1, 0, 3, 0, 0);
    run_a("load_prio");
  endtask

  task automatic test_enable_dir();
    plan(1, 0, 1, 0, 6, 6, 0, 0);
    plan(0, 0, 1, 0, 0, 6, 0, 0);
    plan(0, 0, 1, 0, 0, 6, 0, 0);
    plan(0, 0, 1, 0, 0, 6, 0, 0);
    plan(0, 1, 0, 0, 0, 5, 0, 0);
    plan(1, 0, 0, 0, 0, 0, 0, 0);
    plan(0, 1, 1, 0, 0, 1, 0, 0);   // at 0 with up=1 is not terminal
    plan(0, 1, 0, 0, 0, 0, 0, 0);
    plan(0, 1, 1, 0, 0, 1, 0, 0);
    plan(1, 0, 1, 0, 9, 9, 0, 0);
    plan(0, 0, 1, 0, 0, 9, 0, 0);   // terminal but disabled: no pulse
    run_a("enable_dir");
  endtask

  task automatic test_defaults();
    stim_t s;
    exp_t  e;
    int    step;
    plan(1, 1, 1, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 0, 0);
    plan(0, 1, 1, 0, 0, 32'hFFFF_FFFF, 0, 0);
    plan(0, 1, 1, 0, 0, 32'h0000_0000, 1, 0);
    plan(0, 1, 0, 0, 0, 32'hFFFF_FFFF, 1, 0);
    plan(0, 1, 0, 0, 0, 32'hFFFF_FFFE, 0, 0);
    plan(1, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    step = 0;
    while (stq.size() > 0) begin
      s = stq.pop_front();
      b_load = s.load; b_en = s.en; b_up = s.up; b_mode = s.mode; b_pdata = s.pdata;
      tick();
      e = sbq.pop_front();
      checks++;
      if ({b_cnt, b_rc, b_done} !== {e.cnt, e.rc, e.done}) begin
        failures++;
        $display("FAIL defaults step %0d: got cnt=%0h rc=%b done=%b, want cnt=%0h rc=%b done=%b",
                 step, b_cnt, b_rc, b_done, e.cnt, e.rc, e.done);
      end
      step++;
    end
    b_load = 1'b0; b_en = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_wrap();
    test_oneshot();
    test_load_priority();
    test_enable_dir();
    test_defaults();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_counter_updown_param
`default_nettype wire
